// File: rtl/countdown_timer.sv
`default_nettype none
// ============================================================================
// Module   : countdown_timer
// Brief    : HH:MM:SS countdown timer with load/start/stop control, BCD
//            display digits and a one-cycle done pulse on expiry.
// Revision : 1.0 - initial release
// ============================================================================
module countdown_timer #(
    parameter int MAX_HR = 12
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       load,
    input  logic [3:0] load_hr,
    input  logic [5:0] load_min,
    input  logic [5:0] load_sec,
    input  logic       start_resume,
    input  logic       stop,
    output logic [3:0] hr_tens,
    output logic [3:0] hr_ones,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       running,
    output logic       done
);

    localparam logic [3:0] c_max_hr  = 4'(MAX_HR);
    localparam logic [5:0] c_max_ms  = 6'd59;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RUN     = 2'd1,
        S_PAUSE   = 2'd2,
        S_EXPIRED = 2'd3
    } state_t;

    state_t     r_state, w_state_nxt;
    logic [3:0] r_hr, w_hr_nxt;
    logic [5:0] r_min, w_min_nxt;
    logic [5:0] r_sec, w_sec_nxt;
    logic       r_done, w_done_nxt;

    logic       w_nonzero;
    logic       w_last_sec;

    assign w_nonzero  = (r_hr != 4'd0) || (r_min != 6'd0) || (r_sec != 6'd0);
    assign w_last_sec = (r_hr == 4'd0) && (r_min == 6'd0) && (r_sec == 6'd1);

    function automatic logic [7:0] to_bcd(input logic [5:0] v);
        return {4'(v / 6'd10), 4'(v % 6'd10)};
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_hr    <= 4'd0;
            r_min   <= 6'd0;
            r_sec   <= 6'd0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_hr    <= w_hr_nxt;
            r_min   <= w_min_nxt;
            r_sec   <= w_sec_nxt;
            r_done  <= w_done_nxt;
        end
    end

    // Only the highest-priority asserted command is acted on each cycle:
    // load > stop > start_resume > tick.
    always_comb begin
        w_state_nxt = r_state;
        w_hr_nxt    = r_hr;
        w_min_nxt   = r_min;
        w_sec_nxt   = r_sec;
        w_done_nxt  = 1'b0;

        if (load) begin
            if (r_state != S_RUN) begin
                w_state_nxt = S_IDLE;
                w_hr_nxt    = (load_hr  > c_max_hr) ? c_max_hr : load_hr;
                w_min_nxt   = (load_min > c_max_ms) ? c_max_ms : load_min;
                w_sec_nxt   = (load_sec > c_max_ms) ? c_max_ms : load_sec;
            end
        end else if (stop) begin
            if (r_state == S_RUN) begin
                w_state_nxt = S_PAUSE;
            end
        end else if (start_resume) begin
            if ((r_state == S_IDLE || r_state == S_PAUSE) && w_nonzero) begin
                w_state_nxt = S_RUN;
            end
        end else if (tick) begin
            // The zero guard keeps the count from ever wrapping below 00:00:00.
            if (r_state == S_RUN && w_nonzero) begin
                if (r_sec != 6'd0) begin
                    w_sec_nxt = r_sec - 6'd1;
                end else begin
                    w_sec_nxt = c_max_ms;
                    if (r_min != 6'd0) begin
                        w_min_nxt = r_min - 6'd1;
                    end else begin
                        w_min_nxt = c_max_ms;
                        w_hr_nxt  = r_hr - 4'd1;
                    end
                end
                if (w_last_sec) begin
                    w_state_nxt = S_EXPIRED;
                    w_done_nxt  = 1'b1;
                end
            end
        end
    end

    assign {hr_tens,  hr_ones}  = to_bcd({2'b00, r_hr});
    assign {min_tens, min_ones} = to_bcd(r_min);
    assign {sec_tens, sec_ones} = to_bcd(r_sec);
    assign running              = (r_state == S_RUN);
    assign done                 = r_done;

endmodule
`default_nettype wire

// File: tb/tb_countdown_timer.sv
`default_nettype none
// ============================================================================
// Module   : tb_countdown_timer
// Brief    : Self-checking bench for countdown_timer against a seconds-based
//            reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_countdown_timer;

    localparam int c_max_hr = 12;
    localparam int c_stopped = 0, c_running = 1, c_expired = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       tick = 1'b0, load = 1'b0, start_resume = 1'b0, stop = 1'b0;
    logic [3:0] load_hr = 4'd0;
    logic [5:0] load_min = 6'd0, load_sec = 6'd0;
    logic [3:0] hr_tens, hr_ones, min_tens, min_ones, sec_tens, sec_ones;
    logic       running, done;
    logic [23:0] dig;

    int total = 0;
    int bad   = 0;

    // Reference model: remaining time as a plain number of seconds.
    int m_secs = 0;
    int m_mode = c_stopped;
    bit m_done = 1'b0;

    countdown_timer #(.MAX_HR(c_max_hr)) dut (
        .clk(clk), .reset(reset), .tick(tick), .load(load),
        .load_hr(load_hr), .load_min(load_min), .load_sec(load_sec),
        .start_resume(start_resume), .stop(stop),
        .hr_tens(hr_tens), .hr_ones(hr_ones), .min_tens(min_tens),
        .min_ones(min_ones), .sec_tens(sec_tens), .sec_ones(sec_ones),
        .running(running), .done(done)
    );

    always #5 clk = ~clk;

    assign dig = {hr_tens, hr_ones, min_tens, min_ones, sec_tens, sec_ones};

    function automatic logic [23:0] exp_digits(input int secs);
        int h, m, s;
        h = secs / 3600;
        m = (secs / 60) % 60;
        s = secs % 60;
        return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
    endfunction

    function automatic int sat(input int v, input int lim);
        return (v > lim) ? lim : v;
    endfunction

    task automatic model_reset();
        m_secs = 0;
        m_mode = c_stopped;
        m_done = 1'b0;
    endtask

    task automatic model_update(input bit ld, input bit st, input bit sr, input bit tk,
                                input int h, input int m, input int s);
        m_done = 1'b0;
        if (ld) begin
            if (m_mode != c_running) begin
                m_secs = sat(h, c_max_hr) * 3600 + sat(m, 59) * 60 + sat(s, 59);
                m_mode = c_stopped;
            end
        end else if (st) begin
            if (m_mode == c_running) m_mode = c_stopped;
        end else if (sr) begin
            if (m_mode == c_stopped && m_secs > 0) m_mode = c_running;
        end else if (tk) begin
            if (m_mode == c_running && m_secs > 0) begin
                m_secs = m_secs - 1;
                if (m_secs == 0) begin
                    m_mode = c_expired;
                    m_done = 1'b1;
                end
            end
        end
    endtask

    // Drive one cycle of inputs, clock it, then advance the model.
    task automatic step(input bit ld, input bit st, input bit sr, input bit tk,
                        input int h = 0, input int m = 0, input int s = 0);
        load = ld; stop = st; start_resume = sr; tick = tk;
        load_hr = 4'(h); load_min = 6'(m); load_sec = 6'(s);
        @(posedge clk);
        #1;
        model_update(ld, st, sr, tk, h, m, s);
        load = 1'b0; stop = 1'b0; start_resume = 1'b0; tick = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        total++;
        if (dig !== 24'h000000) begin
            bad++; $display("FAIL reset_digits: got %h expected 000000", dig);
        end
        total++;
        if (running !== 1'b0 || done !== 1'b0) begin
            bad++; $display("FAIL reset_flags: got running=%b done=%b expected 0 0", running, done);
        end
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_expire();
        step(1, 0, 0, 0, 0, 0, 3);
        step(0, 0, 1, 0);
        total++;
        if (running !== 1'b1) begin
            bad++; $display("FAIL expire_start: got running=%b expected 1", running);
        end
        for (int i = 2; i >= 0; i--) begin
            step(0, 0, 0, 1);
            total++;
            if (dig !== 24'(i)) begin
                bad++; $display("FAIL expire_count: got %h expected %h", dig, 24'(i));
            end
        end
        total++;
        if (done !== 1'b1 || running !== 1'b0) begin
            bad++; $display("FAIL expire_done: got done=%b running=%b expected 1 0", done, running);
        end
        step(0, 0, 1, 1);
        total++;
        if (done !== 1'b0 || running !== 1'b0 || dig !== 24'h000000) begin
            bad++; $display("FAIL expire_hold: got done=%b running=%b dig=%h expected 0 0 000000",
                            done, running, dig);
        end
    endtask

    task automatic test_borrow();
        step(1, 0, 0, 0, 1, 0, 0);
        step(0, 0, 1, 0);
        step(0, 0, 0, 1);
        total++;
        if (dig !== 24'h005959 || running !== 1'b1) begin
            bad++; $display("FAIL borrow: got %h running=%b expected 005959 1", dig, running);
        end
        step(0, 1, 0, 0);
    endtask

    task automatic test_saturate();
        step(1, 0, 0, 0, 15, 63, 60);
        total++;
        if (dig !== 24'h125959) begin
            bad++; $display("FAIL saturate_load: got %h expected 125959", dig);
        end
        step(0, 0, 1, 0);
        step(0, 0, 0, 0);
        total++;
        if (dig !== 24'h125959 || running !== 1'b1) begin
            bad++; $display("FAIL saturate_notick: got %h running=%b expected 125959 1", dig, running);
        end
        step(0, 1, 0, 0);
    endtask

    task automatic test_stop_tick();
        step(1, 0, 0, 0, 0, 0, 10);
        step(0, 0, 1, 0);
        step(0, 1, 0, 1);
        total++;
        if (dig !== 24'h000010 || running !== 1'b0) begin
            bad++; $display("FAIL stop_tick: got %h running=%b expected 000010 0", dig, running);
        end
        repeat (3) step(0, 0, 0, 1);
        total++;
        if (dig !== 24'h000010) begin
            bad++; $display("FAIL pause_ticks: got %h expected 000010", dig);
        end
        step(0, 0, 1, 0);
        total++;
        if (running !== 1'b1) begin
            bad++; $display("FAIL resume: got running=%b expected 1", running);
        end
        step(0, 0, 0, 1);
        total++;
        if (dig !== 24'h000009) begin
            bad++; $display("FAIL resume_tick: got %h expected 000009", dig);
        end
        step(0, 1, 0, 0);
    endtask

    task automatic test_zero_and_load_in_run();
        step(1, 0, 0, 0, 0, 0, 0);
        step(0, 0, 1, 0);
        total++;
        if (running !== 1'b0 || done !== 1'b0 || dig !== 24'h000000) begin
            bad++; $display("FAIL zero_start: got running=%b done=%b dig=%h expected 0 0 000000",
                            running, done, dig);
        end
        step(1, 0, 0, 0, 0, 0, 5);
        step(0, 0, 1, 0);
        step(1, 0, 0, 0, 0, 0, 40);
        total++;
        if (dig !== 24'h000005 || running !== 1'b1) begin
            bad++; $display("FAIL load_in_run: got %h running=%b expected 000005 1", dig, running);
        end
        step(1, 0, 0, 1, 0, 0, 40);
        total++;
        if (dig !== 24'h000005) begin
            bad++; $display("FAIL load_tick: got %h expected 000005", dig);
        end
        step(0, 1, 0, 0);
    endtask

    task automatic test_reset_mid();
        step(1, 0, 0, 0, 0, 5, 0);
        step(0, 0, 1, 0);
        #2 reset = 1'b1;
        #1;
        total++;
        if (dig !== 24'h000000 || running !== 1'b0 || done !== 1'b0) begin
            bad++; $display("FAIL reset_mid: got %h running=%b done=%b expected 000000 0 0",
                            dig, running, done);
        end
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        repeat (2) step(0, 0, 0, 1);
        total++;
        if (running !== 1'b0 || dig !== 24'h000000) begin
            bad++; $display("FAIL reset_idle: got running=%b dig=%h expected 0 000000", running, dig);
        end
        // Abort a done pulse.
        step(1, 0, 0, 0, 0, 0, 1);
        step(0, 0, 1, 0);
        step(0, 0, 0, 1);
        #1 reset = 1'b1;
        #1;
        total++;
        if (done !== 1'b0) begin
            bad++; $display("FAIL reset_done: got done=%b expected 0", done);
        end
        model_reset();
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            bit ld, st, sr, tk;
            int h, m, s;
            ld = ($urandom % 14) == 0;
            st = ($urandom % 12) == 0;
            sr = ($urandom % 5) == 0;
            tk = ($urandom % 2) == 0;
            if ($urandom % 2) begin
                h = 0; m = $urandom_range(0, 1); s = $urandom_range(0, 6);
            end else begin
                h = $urandom_range(0, 15); m = $urandom_range(0, 63); s = $urandom_range(0, 63);
            end
            step(ld, st, sr, tk, h, m, s);
            total++;
            if (dig !== exp_digits(m_secs)) begin
                bad++; $display("FAIL rand_digits[%0d]: got %h expected %h", i, dig, exp_digits(m_secs));
            end
            total++;
            if (running !== (m_mode == c_running)) begin
                bad++; $display("FAIL rand_running[%0d]: got %b expected %b", i, running, m_mode == c_running);
            end
            total++;
            if (done !== m_done) begin
                bad++; $display("FAIL rand_done[%0d]: got %b expected %b", i, done, m_done);
            end
        end
    endtask

    initial begin
        test_reset();
        test_expire();
        test_borrow();
        test_saturate();
        test_stop_tick();
        test_zero_and_load_in_run();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
